// File: rtl/calc_bcd_fmt.sv
`default_nettype none
// ============================================================================
// Module   : calc_bcd_fmt
// Purpose  : Sequential binary-to-BCD result formatter for the divider
//            output. On a start strobe it captures the 8-bit quotient and
//            remainder magnitudes plus the negative flag. Both magnitudes are
//            converted to 3-digit packed BCD by two shift-add-3 engines that
//            share one 8-step sequencer. The results, a display sign and a
//            one-cycle valid pulse are then presented to the display driver.
// Ports    : clk    - system clock, rising edge
//            rst    - asynchronous active-high reset
//            start  - conversion request, sampled only while idle
//            q, r   - quotient / remainder magnitudes (unsigned 8-bit)
//            neg    - result-negative flag from the divider
//            busy   - conversion in progress
//            valid  - one-cycle pulse, outputs updated this cycle
//            q_bcd  - quotient digits {hundreds, tens, ones}
//            r_bcd  - remainder digits {hundreds, tens, ones}
//            sign   - display minus sign (suppressed for a zero quotient)
// Options  : CALC_BCD_ZERO_BLANK_EN - when defined, leading zero digits are
//            replaced by the blank code 4'hF as results are loaded.
// Revision : 1.0 - initial release
// ============================================================================
module calc_bcd_fmt (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  q,
  input  logic [7:0]  r,
  input  logic        neg,
  output logic        busy,
  output logic        valid,
  output logic [11:0] q_bcd,
  output logic [11:0] r_bcd,
  output logic        sign
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  q_bin_q, q_bin_d;
  logic [7:0]  r_bin_q, r_bin_d;
  logic [11:0] q_acc_q, q_acc_d;
  logic [11:0] r_acc_q, r_acc_d;
  logic        sign_pend_q, sign_pend_d;
  logic        valid_q, valid_d;
  logic [11:0] q_bcd_q, q_bcd_d;
  logic [11:0] r_bcd_q, r_bcd_d;
  logic        sign_q, sign_d;

  logic [11:0] q_adj, r_adj;
  logic [11:0] q_acc_nxt, r_acc_nxt;
  logic        unused_msb;

  // Add 3 to every digit that is 5 or more; each nibble wraps on its own.
  function automatic logic [11:0] add3(input logic [11:0] d);
    logic [11:0] res;
    for (int i = 0; i < 3; i++) begin
      res[i*4 +: 4] = (d[i*4 +: 4] >= 4'd5) ? d[i*4 +: 4] + 4'd3 : d[i*4 +: 4];
    end
    return res;
  endfunction

  // Final digit presentation applied when results are loaded.
  function automatic logic [11:0] fmt_digits(input logic [11:0] d);
    logic [11:0] res;
    res = d;
`ifdef CALC_BCD_ZERO_BLANK_EN
    if (d[11:8] == 4'd0) begin
      res[11:8] = 4'hF;
      if (d[7:4] == 4'd0) begin
        res[7:4] = 4'hF;
      end
    end
`endif
    return res;
  endfunction

  // One double-dabble step per engine: adjust, then shift {acc, bin} left.
  // The accumulator MSB shifted out is always zero because the value never
  // exceeds 255 (hundreds digit at most 2).
  always_comb begin
    q_adj     = add3(q_acc_q);
    r_adj     = add3(r_acc_q);
    q_acc_nxt = {q_adj[10:0], q_bin_q[7]};
    r_acc_nxt = {r_adj[10:0], r_bin_q[7]};
  end

  assign unused_msb = q_adj[11] ^ r_adj[11];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_bin_d     = q_bin_q;
    r_bin_d     = r_bin_q;
    q_acc_d     = q_acc_q;
    r_acc_d     = r_acc_q;
    sign_pend_d = sign_pend_q;
    valid_d     = 1'b0;
    q_bcd_d     = q_bcd_q;
    r_bcd_d     = r_bcd_q;
    sign_d      = sign_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_bin_d     = q;
          r_bin_d     = r;
          q_acc_d     = 12'h000;
          r_acc_d     = 12'h000;
          // Qualify the sign at capture so no "-0" is ever displayed.
          sign_pend_d = neg & (q != 8'd0);
          cnt_d       = 3'd0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        q_acc_d = q_acc_nxt;
        r_acc_d = r_acc_nxt;
        q_bin_d = {q_bin_q[6:0], 1'b0};
        r_bin_d = {r_bin_q[6:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          q_bcd_d = fmt_digits(q_acc_nxt);
          r_bcd_d = fmt_digits(r_acc_nxt);
          sign_d  = sign_pend_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      q_bin_q     <= 8'd0;
      r_bin_q     <= 8'd0;
      q_acc_q     <= 12'h000;
      r_acc_q     <= 12'h000;
      sign_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      q_bcd_q     <= 12'h000;
      r_bcd_q     <= 12'h000;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_bin_q     <= q_bin_d;
      r_bin_q     <= r_bin_d;
      q_acc_q     <= q_acc_d;
      r_acc_q     <= r_acc_d;
      sign_pend_q <= sign_pend_d;
      valid_q     <= valid_d;
      q_bcd_q     <= q_bcd_d;
      r_bcd_q     <= r_bcd_d;
      sign_q      <= sign_d;
    end
  end

  assign busy  = (state_q == SHIFT);
  assign valid = valid_q;
  assign q_bcd = q_bcd_q;
  assign r_bcd = r_bcd_q;
  assign sign  = sign_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_bcd_fmt.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_bcd_fmt
// Purpose  : Directed self-checking bench for calc_bcd_fmt. Expected digit
//            values are hand-computed for both the raw and the leading-zero
//            blanked build (CALC_BCD_ZERO_BLANK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_bcd_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        neg;
  logic        busy;
  logic        valid;
  logic [11:0] q_bcd;
  logic [11:0] r_bcd;
  logic        sign;

  int n_tests = 0;
  int n_fail  = 0;

  calc_bcd_fmt u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .q     (q),
    .r     (r),
    .neg   (neg),
    .busy  (busy),
    .valid (valid),
    .q_bcd (q_bcd),
    .r_bcd (r_bcd),
    .sign  (sign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Selects the hand-computed expectation matching the build option.
  function automatic logic [11:0] pick(input logic [11:0] raw, input logic [11:0] blk);
`ifdef CALC_BCD_ZERO_BLANK_EN
    return blk;
`else
    return raw;
`endif
  endfunction

  // Single conversion: pulse start, measure latency, check results and hold.
  task automatic run(input string tag, input logic [7:0] qi, input logic [7:0] ri,
                     input logic ni, input logic [11:0] eq, input logic [11:0] er,
                     input logic es);
    int lat;
    lat = 99;
    @(negedge clk);
    q = qi; r = ri; neg = ni; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Inputs are free to change while converting.
    q = ~qi; r = ~ri; neg = ~ni;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_q_bcd"}, {20'd0, q_bcd}, {20'd0, eq});
    check({tag, "_r_bcd"}, {20'd0, r_bcd}, {20'd0, er});
    check({tag, "_sign"}, {31'd0, sign}, {31'd0, es});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, {31'd0, valid}, 32'd0);
    check({tag, "_q_hold"}, {20'd0, q_bcd}, {20'd0, eq});
  endtask

  initial begin
    int vcnt;
    int vat;
    int first;
    int last;

    rst = 1'b0; start = 1'b0; q = 8'd0; r = 8'd0; neg = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_q_bcd", {20'd0, q_bcd}, 32'd0);
    check("rst_r_bcd", {20'd0, r_bcd}, 32'd0);
    check("rst_sign",  {31'd0, sign},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("v123", 8'd123, 8'd45, 1'b0, pick(12'h123, 12'h123), pick(12'h045, 12'hF45), 1'b0);
    run("v255", 8'd255, 8'd0,  1'b1, pick(12'h255, 12'h255), pick(12'h000, 12'hFF0), 1'b1);
    run("v0",   8'd0,   8'd7,  1'b1, pick(12'h000, 12'hFF0), pick(12'h007, 12'hFF7), 1'b0);
    run("v9",   8'd9,   8'd99, 1'b0, pick(12'h009, 12'hFF9), pick(12'h099, 12'hF99), 1'b0);

    // Extra start pulses at E3 and E8 must be ignored.
    @(negedge clk);
    q = 8'd42; r = 8'd3; neg = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vcnt = 0; vat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 8);
      @(posedge clk); #1;
      if (valid) begin
        vcnt++;
        vat = k;
      end
      if (k == 9) check("ign_busy_e9", {31'd0, busy}, 32'd0);
    end
    start = 1'b0;
    check("ign_vcount", vcnt, 32'd1);
    check("ign_vat",    vat,  32'd8);
    check("ign_q_bcd",  {20'd0, q_bcd}, {20'd0, pick(12'h042, 12'hF42)});
    check("ign_r_bcd",  {20'd0, r_bcd}, {20'd0, pick(12'h003, 12'hFF3)});

    // Reset at E4 aborts the conversion of q=200.
    @(negedge clk);
    q = 8'd200; r = 8'd5; neg = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",  {31'd0, busy},  32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_q_bcd", {20'd0, q_bcd}, 32'd0);
    check("abort_r_bcd", {20'd0, r_bcd}, 32'd0);
    check("abort_sign",  {31'd0, sign},  32'd0);
    vcnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
    end
    check("abort_no_valid", vcnt, 32'd0);
    run("v200", 8'd200, 8'd5, 1'b1, pick(12'h200, 12'h200), pick(12'h005, 12'hFF5), 1'b1);

    // Continuous start: one result every 9 cycles.
    @(negedge clk);
    q = 8'd9; r = 8'd99; neg = 1'b1; start = 1'b1;
    vcnt = 0; first = -1; last = -1;
    for (int k = 0; k < 28; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        vcnt++;
        if (first < 0) first = k;
        last = k;
        check("cont_q_bcd", {20'd0, q_bcd}, {20'd0, pick(12'h009, 12'hFF9)});
        check("cont_r_bcd", {20'd0, r_bcd}, {20'd0, pick(12'h099, 12'hF99)});
        check("cont_sign",  {31'd0, sign},  32'd1);
      end
    end
    start = 1'b0;
    check("cont_count", vcnt, 32'd3);
    check("cont_first", first, 32'd8);
    check("cont_span",  last - first, 32'd18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
